// File: rtl/chacha_ks_arbiter_pkg.sv
// Shared widths, FSM encoding and counter helper for the ChaCha keystream arbiter.
package chacha_arb_pkg;

   localparam int KEY_W   = 256;
   localparam int NONCE_W = 96;
   localparam int CTR_W   = 32;
   localparam int BLK_W   = 512;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_ISSUE = 2'd2,
      ST_DONE  = 2'd3
   } arb_state_e;

   // Returns {wrapped, next}; wrapped is set when the old counter was all ones.
   function automatic logic [CTR_W:0] ctr_advance(input logic [CTR_W-1:0] ctr);
      return {1'b0, ctr} + {{CTR_W{1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/chacha_ks_arbiter_if.sv
// Config/request/block bus between the arbiter (master) and the keystream unit (slave).
interface chacha_ks_arbiter_if;
   import chacha_arb_pkg::*;

   logic               ks_cfg_we;
   logic [KEY_W-1:0]   ks_key;
   logic [NONCE_W-1:0] ks_nonce;
   logic [CTR_W-1:0]   ks_ctr;
   logic               ks_req;
   logic               ks_valid;
   logic [BLK_W-1:0]   ks_data;

   modport master (
      output ks_cfg_we, ks_key, ks_nonce, ks_ctr, ks_req,
      input  ks_valid, ks_data
   );

   modport slave (
      input  ks_cfg_we, ks_key, ks_nonce, ks_ctr, ks_req,
      output ks_valid, ks_data
   );
endinterface

// File: rtl/chacha_ks_arbiter_rr_pick.sv
// Combinational round-robin picker: first set mask bit at or after ptr, wrapping.
module rr_pick #(
   parameter  int NREQ  = 2,
   localparam int IDX_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  mask,
   input  logic [IDX_W-1:0] ptr,
   output logic [NREQ-1:0]  gnt,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   // Scan from ptr; only the first hit is recorded.
   always_comb begin
      int   pos_s;
      logic hit_s;
      gnt   = '0;
      idx   = '0;
      any   = 1'b0;
      pos_s = 0;
      hit_s = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         pos_s      = (int'(ptr) + i) % NREQ;
         hit_s      = !any && mask[pos_s];
         gnt[pos_s] = gnt[pos_s] | hit_s;
         idx        = hit_s ? IDX_W'(pos_s) : idx;
         any        = any | hit_s;
      end
   end

endmodule

// File: rtl/chacha_ks_arbiter.sv
// Round-robin sharing of one ChaCha keystream unit across NREQ stream contexts,
// one 512-bit block per grant, with per-context counter advance and watchdog.
module chacha_ks_arbiter
   import chacha_arb_pkg::*;
#(
   parameter  int NREQ    = 2,
   parameter  int TIMEOUT = 1023,
   localparam int IDX_W   = $clog2(NREQ),
   localparam int WD_W    = $clog2(TIMEOUT + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ctx_we,
   input  logic [IDX_W-1:0]   ctx_id,
   input  logic [KEY_W-1:0]   ctx_key,
   input  logic [NONCE_W-1:0] ctx_nonce,
   input  logic [CTR_W-1:0]   ctx_ctr,
   input  logic [NREQ-1:0]    req,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    blk_valid,
   output logic [BLK_W-1:0]   blk_data,
   output logic [CTR_W-1:0]   blk_ctr,
   output logic [NREQ-1:0]    ctr_exhausted,
   output logic               err_timeout,
   chacha_ks_arbiter_if.master ks
);

   arb_state_e         state_r;
   logic [IDX_W-1:0]   owner_r;
   logic [IDX_W-1:0]   rr_ptr_r;
   logic [WD_W-1:0]    wdog_r;
   logic [NREQ-1:0]    gnt_r;
   logic [NREQ-1:0]    blk_valid_r;
   logic [BLK_W-1:0]   blk_data_r;
   logic [CTR_W-1:0]   blk_ctr_r;
   logic               err_timeout_r;
   logic               ks_cfg_we_r;
   logic [KEY_W-1:0]   ks_key_r;
   logic [NONCE_W-1:0] ks_nonce_r;
   logic [CTR_W-1:0]   ks_ctr_r;
   logic               ks_req_r;

   logic [KEY_W-1:0]   ctx_key_r   [NREQ];
   logic [NONCE_W-1:0] ctx_nonce_r [NREQ];
   logic [CTR_W-1:0]   ctx_ctr_r   [NREQ];
   logic [NREQ-1:0]    exhausted_r;

   logic [NREQ-1:0]    eligible_s;
   logic [NREQ-1:0]    pick_oh_s;
   logic [IDX_W-1:0]   pick_idx_s;
   logic               pick_any_s;
   logic [CTR_W:0]     owner_adv_s;

   assign eligible_s  = req & ~exhausted_r;
   assign owner_adv_s = ctr_advance(ctx_ctr_r[owner_r]);

   rr_pick #(.NREQ(NREQ)) u_rr_pick (
      .mask (eligible_s),
      .ptr  (rr_ptr_r),
      .gnt  (pick_oh_s),
      .idx  (pick_idx_s),
      .any  (pick_any_s)
   );

   // Context storage; a host write in the DONE cycle overrides the counter advance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREQ; i++) begin
            ctx_key_r[i]   <= '0;
            ctx_nonce_r[i] <= '0;
            ctx_ctr_r[i]   <= '0;
         end
         exhausted_r <= '0;
      end else begin
         if (state_r == ST_DONE) begin
            ctx_ctr_r[owner_r] <= owner_adv_s[CTR_W-1:0];
            if (owner_adv_s[CTR_W]) begin
               exhausted_r[owner_r] <= 1'b1;
            end
         end
         if (ctx_we && (int'(ctx_id) < NREQ)) begin
            ctx_key_r[ctx_id]   <= ctx_key;
            ctx_nonce_r[ctx_id] <= ctx_nonce;
            ctx_ctr_r[ctx_id]   <= ctx_ctr;
            exhausted_r[ctx_id] <= 1'b0;
         end
      end
   end

   // Block sequencer: grant, load config, wait for the unit, deliver.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= ST_IDLE;
         owner_r       <= '0;
         rr_ptr_r      <= '0;
         wdog_r        <= '0;
         gnt_r         <= '0;
         blk_valid_r   <= '0;
         blk_data_r    <= '0;
         blk_ctr_r     <= '0;
         err_timeout_r <= 1'b0;
         ks_cfg_we_r   <= 1'b0;
         ks_key_r      <= '0;
         ks_nonce_r    <= '0;
         ks_ctr_r      <= '0;
         ks_req_r      <= 1'b0;
      end else begin
         ks_cfg_we_r   <= 1'b0;
         blk_valid_r   <= '0;
         err_timeout_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (pick_any_s) begin
                  owner_r     <= pick_idx_s;
                  gnt_r       <= pick_oh_s;
                  ks_key_r    <= ctx_key_r[pick_idx_s];
                  ks_nonce_r  <= ctx_nonce_r[pick_idx_s];
                  ks_ctr_r    <= ctx_ctr_r[pick_idx_s];
                  ks_cfg_we_r <= 1'b1;
                  state_r     <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               ks_req_r <= 1'b1;
               wdog_r   <= '0;
               state_r  <= ST_ISSUE;
            end
            ST_ISSUE: begin
               if (ks.ks_valid) begin
                  blk_data_r  <= ks.ks_data;
                  blk_ctr_r   <= ks_ctr_r;
                  blk_valid_r <= gnt_r;
                  ks_req_r    <= 1'b0;
                  state_r     <= ST_DONE;
               end else if (wdog_r == WD_W'(TIMEOUT - 1)) begin
                  // Abort leaves counter and rr_ptr untouched so the same context retries.
                  err_timeout_r <= 1'b1;
                  gnt_r         <= '0;
                  ks_req_r      <= 1'b0;
                  state_r       <= ST_IDLE;
               end else begin
                  wdog_r <= wdog_r + WD_W'(1);
               end
            end
            ST_DONE: begin
               gnt_r    <= '0;
               rr_ptr_r <= (owner_r == IDX_W'(NREQ - 1)) ? '0 : owner_r + IDX_W'(1);
               state_r  <= ST_IDLE;
            end
            default: begin
               gnt_r    <= '0;
               ks_req_r <= 1'b0;
               state_r  <= ST_IDLE;
            end
         endcase
      end
   end

   assign gnt           = gnt_r;
   assign blk_valid     = blk_valid_r;
   assign blk_data      = blk_data_r;
   assign blk_ctr       = blk_ctr_r;
   assign ctr_exhausted = exhausted_r;
   assign err_timeout   = err_timeout_r;
   assign ks.ks_cfg_we  = ks_cfg_we_r;
   assign ks.ks_key     = ks_key_r;
   assign ks.ks_nonce   = ks_nonce_r;
   assign ks.ks_ctr     = ks_ctr_r;
   assign ks.ks_req     = ks_req_r;

endmodule
